// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Shift-register scoreboard of in-flight writes (EX..WB) that
//               produces the decode stall and registered EX bypass selects.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int DEPTH  = 3,
    parameter int LD_LAT = 2,
    parameter int AW     = $clog2(NREG),
    parameter int SW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          id_rs1_used,
    input  logic          id_rs2_used,
    input  logic          id_we,
    input  logic [AW-1:0] id_rd,
    input  logic          id_is_load,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] ex_fwd1,
    output logic [SW-1:0] ex_fwd2,
    output logic          ex_valid,
    output logic [31:0]   stall_cnt
);

    // Entry k: valid, we, rd and a load flag (rdy = LD_LAT for loads, else 1)
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_we;
    logic [DEPTH-1:0] r_ld;
    logic [AW-1:0]    r_rd [DEPTH];
    logic [SW-1:0]    r_fwd1;
    logic [SW-1:0]    r_fwd2;
    logic [31:0]      r_stall_cnt;

    logic [AW-1:0] w_src  [2];
    logic          w_used [2];
    logic          w_hz   [2];
    logic [SW-1:0] w_fwd  [2];
    logic          w_stall;
    logic          w_accept;

    assign w_src[0]  = id_rs1;
    assign w_src[1]  = id_rs2;
    assign w_used[0] = id_rs1_used;
    assign w_used[1] = id_rs2_used;

    // Scan oldest to youngest so the youngest match (smallest k) wins
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_hz[s]  = 1'b0;
            w_fwd[s] = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (w_used[s] && (w_src[s] != '0) && r_valid[k] && r_we[k]
                    && (r_rd[k] == w_src[s])) begin
                    w_hz[s]  = ((r_ld[k] ? LD_LAT : 1) > (k + 1));
                    w_fwd[s] = (k < DEPTH - 1) ? SW'(k + 1) : '0;
                end
            end
        end
    end

    assign w_stall  = id_valid & ~flush & (w_hz[0] | w_hz[1]);
    assign w_accept = id_valid & ~w_stall & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_we    <= '0;
            r_ld    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            r_valid <= {r_valid[DEPTH-2:0], w_accept};
            r_we    <= {r_we[DEPTH-2:0], id_we};
            r_ld    <= {r_ld[DEPTH-2:0], id_is_load};
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_rd[k] <= r_rd[k-1];
            end
            r_rd[0] <= id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd1      <= '0;
            r_fwd2      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_fwd1 <= w_accept ? w_fwd[0] : '0;
            r_fwd2 <= w_accept ? w_fwd[1] : '0;
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign stall     = w_stall;
    assign ex_fwd1   = r_fwd1;
    assign ex_fwd2   = r_fwd2;
    assign ex_valid  = r_valid[0];
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Checks a default and a deep scoreboard against a per-register
//               last-writer model, plus directed pipeline scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_rs1_used = 1'b0;
    logic       id_rs2_used = 1'b0;
    logic       id_we = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_is_load = 1'b0;
    logic       flush = 1'b0;

    logic        stall_o [2];
    logic [1:0]  fwd1_o  [2];
    logic [1:0]  fwd2_o  [2];
    logic        exv_o   [2];
    logic [31:0] cnt_o   [2];

    hazard_scoreboard #(.NREG(32), .DEPTH(3), .LD_LAT(2)) u_def (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_we(id_we), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(stall_o[0]), .ex_fwd1(fwd1_o[0]),
        .ex_fwd2(fwd2_o[0]), .ex_valid(exv_o[0]), .stall_cnt(cnt_o[0])
    );

    hazard_scoreboard #(.NREG(32), .DEPTH(4), .LD_LAT(3)) u_deep (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_we(id_we), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(stall_o[1]), .ex_fwd1(fwd1_o[1]),
        .ex_fwd2(fwd2_o[1]), .ex_valid(exv_o[1]), .stall_cnt(cnt_o[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    // Model: for each register remember the cycle its youngest writer sat in EX
    bit          m_wv [2][32];
    int          m_wt [2][32];
    bit          m_wl [2][32];
    int          cyc = 0;
    bit          started = 1'b0;
    logic [1:0]  e_f1 [2];
    logic [1:0]  e_f2 [2];
    bit          e_v  [2];
    logic [31:0] e_cnt [2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 3 : 4;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic void lookup(input int i, input int s, input bit used,
                                   output bit hz, output int fw);
        int k;
        hz = 1'b0;
        fw = 0;
        if (!used || s == 0 || !m_wv[i][s]) return;
        k = cyc - m_wt[i][s];
        if (k < 0 || k >= depth_of(i)) return;
        hz = ((m_wl[i][s] ? lat_of(i) : 1) > k + 1);
        fw = (k < depth_of(i) - 1) ? k + 1 : 0;
    endfunction

    always @(negedge clk) begin
        bit h1, h2, st, acc;
        int f1, f2;
        for (int i = 0; i < 2; i++) begin
            lookup(i, int'(id_rs1), id_rs1_used, h1, f1);
            lookup(i, int'(id_rs2), id_rs2_used, h2, f2);
            st = id_valid && !flush && (h1 || h2);
            if (started) begin
                chk($sformatf("model_stall[%0d]", i), 32'(stall_o[i]), 32'(st));
                chk($sformatf("model_fwd1[%0d]", i), 32'(fwd1_o[i]), 32'(e_f1[i]));
                chk($sformatf("model_fwd2[%0d]", i), 32'(fwd2_o[i]), 32'(e_f2[i]));
                chk($sformatf("model_exv[%0d]", i), 32'(exv_o[i]), 32'(e_v[i]));
                chk($sformatf("model_cnt[%0d]", i), cnt_o[i], e_cnt[i]);
            end
            if (reset) begin
                for (int r = 0; r < 32; r++) m_wv[i][r] = 1'b0;
                e_f1[i] = '0; e_f2[i] = '0; e_v[i] = 1'b0; e_cnt[i] = '0;
            end else begin
                if (st && e_cnt[i] != 32'hFFFF_FFFF) e_cnt[i] = e_cnt[i] + 1;
                acc = id_valid && !st && !flush;
                e_v[i]  = acc;
                e_f1[i] = acc ? 2'(f1) : 2'd0;
                e_f2[i] = acc ? 2'(f2) : 2'd0;
                if (acc && id_we && id_rd != 0) begin
                    m_wv[i][id_rd] = 1'b1;
                    m_wt[i][id_rd] = cyc + 1;
                    m_wl[i][id_rd] = id_is_load;
                end
            end
        end
        if (reset) started = 1'b1;
        cyc++;
    end

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input bit we, input int rd, input bit ld, input bit fl);
        id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
        id_we = we; id_rd = 5'(rd); id_is_load = ld; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (5) tick();
    endtask

    initial begin
        logic [31:0] base;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_exv0", 32'(exv_o[0]), 0);
        chk("rst_fwd1_0", 32'(fwd1_o[0]), 0);
        chk("rst_cnt1", cnt_o[1], 0);
        chk("rst_stall0", 32'(stall_o[0]), 0);

        // ALU back-to-back
        drive(1, 1, 1, 2, 1, 1, 5, 0, 0); #1;
        chk("alu_stall_a", 32'(stall_o[0]), 0);
        tick();
        drive(1, 5, 1, 1, 1, 1, 6, 0, 0); #1;
        chk("alu_stall_b", 32'(stall_o[0]), 0);
        tick();
        chk("alu_fwd1", 32'(fwd1_o[0]), 1);
        chk("alu_fwd2", 32'(fwd2_o[0]), 0);
        chk("alu_exv", 32'(exv_o[0]), 1);

        // Load-use
        drain();
        drive(1, 1, 1, 0, 0, 1, 6, 1, 0);
        tick();
        drive(1, 6, 1, 6, 1, 1, 7, 0, 0); #1;
        chk("lu_stall", 32'(stall_o[0]), 1);
        tick();
        chk("lu_bubble", 32'(exv_o[0]), 0);
        #1;
        chk("lu_stall_end", 32'(stall_o[0]), 0);
        tick();
        chk("lu_fwd1", 32'(fwd1_o[0]), 2);
        chk("lu_fwd2", 32'(fwd2_o[0]), 2);
        chk("lu_cnt", cnt_o[0], 1);

        // Youngest producer wins
        drain();
        drive(1, 1, 1, 2, 1, 1, 5, 0, 0); tick();
        drive(1, 3, 1, 4, 1, 1, 5, 0, 0); tick();
        idle(); tick();
        drive(1, 5, 1, 0, 0, 1, 8, 0, 0); #1;
        chk("prio_stall", 32'(stall_o[0]), 0);
        tick();
        chk("prio_fwd1", 32'(fwd1_o[0]), 2);

        // Producer at distance 3 reads the register file
        drain();
        drive(1, 1, 1, 2, 1, 1, 9, 0, 0); tick();
        idle(); tick();
        idle(); tick();
        drive(1, 9, 1, 0, 0, 1, 10, 0, 0); tick();
        chk("dist3_fwd1", 32'(fwd1_o[0]), 0);
        chk("dist3_exv", 32'(exv_o[0]), 1);

        // x0 destination and unused source
        drain();
        drive(1, 1, 1, 0, 0, 1, 0, 1, 0); tick();
        drive(1, 0, 1, 0, 1, 1, 11, 0, 0); #1;
        chk("x0_stall", 32'(stall_o[0]), 0);
        tick();
        chk("x0_fwd1", 32'(fwd1_o[0]), 0);
        chk("x0_fwd2", 32'(fwd2_o[0]), 0);
        drain();
        drive(1, 1, 1, 0, 0, 1, 6, 1, 0); tick();
        drive(1, 6, 0, 3, 1, 1, 12, 0, 0); #1;
        chk("unused_stall", 32'(stall_o[0]), 0);
        tick();
        chk("unused_fwd1", 32'(fwd1_o[0]), 0);
        chk("unused_exv", 32'(exv_o[0]), 1);

        // Flush beats stall
        drain();
        base = cnt_o[0];
        drive(1, 1, 1, 0, 0, 1, 6, 1, 0); tick();
        drive(1, 6, 1, 6, 1, 1, 7, 0, 1); #1;
        chk("flush_stall", 32'(stall_o[0]), 0);
        tick();
        chk("flush_exv", 32'(exv_o[0]), 0);
        chk("flush_cnt", cnt_o[0], base);

        // Deep configuration load-use
        idle();
        reset = 1'b1; repeat (2) tick(); reset = 1'b0;
        drive(1, 1, 1, 0, 0, 1, 6, 1, 0); tick();
        drive(1, 6, 1, 0, 0, 1, 7, 0, 0); #1;
        chk("deep_stall_1", 32'(stall_o[1]), 1);
        tick(); #1;
        chk("deep_stall_2", 32'(stall_o[1]), 1);
        tick(); #1;
        chk("deep_stall_3", 32'(stall_o[1]), 0);
        tick();
        chk("deep_fwd1", 32'(fwd1_o[1]), 3);
        chk("deep_exv", 32'(exv_o[1]), 1);
        chk("deep_cnt", cnt_o[1], 2);

        // Reset during the second deep stall cycle
        drain();
        drive(1, 1, 1, 0, 0, 1, 6, 1, 0); tick();
        drive(1, 6, 1, 0, 0, 1, 7, 0, 0); tick(); #1;
        chk("rstmid_stall_before", 32'(stall_o[1]), 1);
        reset = 1'b1;
        tick();
        chk("rstmid_stall", 32'(stall_o[1]), 0);
        chk("rstmid_exv", 32'(exv_o[1]), 0);
        chk("rstmid_fwd1", 32'(fwd1_o[1]), 0);
        chk("rstmid_fwd2", 32'(fwd2_o[1]), 0);
        chk("rstmid_cnt", cnt_o[1], 0);
        reset = 1'b0;
        tick();
        chk("rstmid_accept", 32'(exv_o[1]), 1);

        // Randomized traffic over a small register set
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It sits beside decode and tracks every in-flight register write from EX through WB in a shift-register scoreboard. From that state it generates the decode stall, the EX bubble and flush handling, and registered per-operand bypass selects for EX. Pipeline depth and load-result latency are parameters, so the same block serves deeper memory stages and multi-cycle loads.

## Interface
Parameters:
- `NREG`, 32: architectural register count; `AW = $clog2(NREG)`.
- `DEPTH`, 3: tracked stages after decode; index 0 = EX, DEPTH-1 = WB. Range 2..8.
- `LD_LAT`, 2: stage index at which load data first becomes forwardable. Range 1..DEPTH-1. ALU results are forwardable from stage 1.
- `SW = $clog2(DEPTH)`: width of the bypass selects.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: decode holds a real instruction.
- `id_rs1`, `id_rs2` in AW: decode source registers.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_we` in 1: instruction writes `id_rd`.
- `id_rd` in AW: destination register.
- `id_is_load` in 1: result arrives at stage LD_LAT.
- `flush` in 1: taken branch resolved in EX; kill the decode-stage instruction.
- `stall` out 1: hold fetch and decode this cycle (combinational).
- `ex_fwd1`, `ex_fwd2` out SW: registered bypass select for the instruction in EX. 0 = register file; k = stage k result.
- `ex_valid` out 1: EX slot holds a real instruction.
- `stall_cnt` out 32: count of cycles with `stall` high, saturating.

## Operation
- Scoreboard entry k holds {valid, we, rd, rdy}. `rdy` = LD_LAT for loads, 1 otherwise. Entries with `rd` = x0 or `we` = 0 never match.
- Match for source s at entry k: s_used & entry.valid & entry.we & entry.rd == s & s != 0.
- Youngest match wins, i.e. the smallest k.
- Hazard: the youngest match at entry k has rdy > k+1, meaning the data is not ready when the consumer reaches EX.
- `stall` = id_valid & ~flush & (hazard on rs1 | hazard on rs2).
- Every cycle entry[k+1] <= entry[k]; entry DEPTH-1 retires. The register file is write-before-read, so no tracking is needed past WB.
- entry[0] loads the decode instruction when id_valid & ~stall & ~flush. Otherwise entry[0] becomes a bubble (valid = 0).
- On load of entry[0], `ex_fwd` for each source:
  - k+1 if the youngest match is at k < DEPTH-1;
  - 0 if there is no match or the match is at DEPTH-1.
- On a bubble, `ex_fwd` = 0.
- `ex_valid` = entry[0].valid.
- `flush` has priority over `stall`: the killed instruction causes no stall and no stall count.
- `stall_cnt` increments on each stall cycle and saturates at 0xFFFF_FFFF.

## Timing
- Reset, synchronous: all entries invalid; `ex_fwd1`/`ex_fwd2` = 0; `ex_valid` = 0; `stall_cnt` = 0. `stall` = 0 because no entries are valid.
- `stall` is combinational, valid in the same cycle as the decode inputs.
- `ex_fwd*` and `ex_valid` change one cycle after decode acceptance, aligned with the instruction in EX.
- Stall length for a producer at distance d (d = 1 means immediately preceding): max(0, rdy - d) cycles.
- With defaults, load-use costs 1 cycle. LD_LAT = 3 with DEPTH = 4 costs 2 cycles.
- Reset asserted mid-stall: the next cycle has no stall and an empty scoreboard. The decode instruction is accepted on the first cycle after reset deasserts.
- A producer and consumer using the same register in one instruction (e.g. addi x5, x5, 1) checks only older entries; there is no self-hazard.

## Test plan
- ALU back-to-back (defaults): add x5 then add x6, x5, x1. Required: `stall` = 0; next cycle `ex_fwd1` = 1, `ex_fwd2` = 0, `ex_valid` = 1.
- Load-use (defaults): lw x6 then add x7, x6, x6. Required: `stall` = 1 for exactly 1 cycle and `ex_valid` = 0 for the bubble. Then `ex_fwd1` = `ex_fwd2` = 2 and `stall_cnt` = 1.
- Distance and priority: add x5; add x5; nop; consumer of x5. Required: the younger producer wins, giving `ex_fwd1` = 2. A producer at distance 3 gives `ex_fwd1` = 0.
- x0 and unused sources: lw x0, then a consumer of x0; also lw x6, then an instruction with rs1 = x6 but `id_rs1_used` = 0. Required: `stall` = 0 and `ex_fwd` = 0 in both cases.
- Flush versus stall: load-use pair with `flush` = 1 in the hazard cycle. Required: `stall` = 0, EX gets a bubble, `stall_cnt` is unchanged.
- Deep configuration (DEPTH = 4, LD_LAT = 3): lw then dependent add. Required: 2 stall cycles, then `ex_fwd1` = 3. Reset asserted during the second stall cycle: next cycle all outputs are 0.
